w_74hc00_checker: RTL



---
 rtl/w_74hc00_checker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/w_74hc00_checker.sv
// Exhaustive tester for a quad 2-input NAND block: sweeps all 256 {A,B} vectors,
// samples the synchronized Y after a settle window and records per-gate failures.
module w_74hc00_checker #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    input  logic [3:0] y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic       fail_valid,
    output logic [7:0] fail_vec
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 32'd1);

    state_t     state_q, state_d;
    logic [7:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic       fail_valid_q, fail_valid_d;
    logic [7:0] fail_vec_q, fail_vec_d;
    logic [3:0] y_meta_q;
    logic [3:0] y_s_q;
    logic [3:0] mism_s;

    // Gate pins are driven straight from the vector register, which is zero outside a run.
    assign a_out      = vec_q[7:4];
    assign b_out      = vec_q[3:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_mask  = fail_mask_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

    assign mism_s = y_s_q ^ ~(vec_q[7:4] & vec_q[3:0]);

    // Next-state and result update for the sweep sequencer.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_mask_d  = fail_mask_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_APPLY;
                    vec_d        = 8'h00;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_mask_d  = 4'h0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = 8'h00;
                end else begin
                    state_d = state_q;
                end
            end
            S_APPLY: begin
                state_d = S_SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SAMPLE: begin
                fail_mask_d = fail_mask_q | mism_s;
                if ((mism_s != 4'h0) && !fail_valid_q) begin
                    fail_valid_d = 1'b1;
                    fail_vec_d   = vec_q;
                end else begin
                    fail_valid_d = fail_valid_q;
                end
                if (vec_q == 8'hFF) begin
                    state_d = S_DONE;
                    vec_d   = 8'h00;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = ~|fail_mask_d;
                end else begin
                    state_d = S_APPLY;
                    vec_d   = vec_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, results and the two-flop Y synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vec_q        <= 8'h00;
            cnt_q        <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_mask_q  <= 4'h0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 8'h00;
            y_meta_q     <= 4'h0;
            y_s_q        <= 4'h0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_mask_q  <= fail_mask_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            y_meta_q     <= y_in;
            y_s_q        <= y_meta_q;
        end
    end

endmodule
